// File: rtl/adder_pkg.sv
// Shared constants, state encoding and width helper for the adder result accumulator.
package adder_pkg;

  localparam int unsigned ADDER_DATA_W = 12;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
    return dw + $clog2(n);
  endfunction

endpackage

// File: rtl/adder_acc_ctrl.sv
// Window controller: ACCUM/HOLD FSM, sample counter and handshakes.
// Exports accept/close/release strobes that steer the accumulator datapath.
module adder_acc_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 16,
  localparam int unsigned CNT_W = $clog2(N_SAMPLES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             accept_c,
  output logic             close_c,
  output logic             release_c
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SAMPLES);

  acc_state_e       state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             out_valid_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      out_valid <= out_valid_n;
    end
  end

  // count parks at N_SAMPLES while HOLD so out_count reports the closed window.
  always_comb begin
    state_n     = state;
    count_n     = count;
    out_valid_n = out_valid;
    in_ready    = 1'b0;
    accept_c    = 1'b0;
    close_c     = 1'b0;
    release_c   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = !clear;
        if (clear) begin
          count_n = '0;
        end else if (in_valid) begin
          accept_c = 1'b1;
          if (count == LAST_IDX) begin
            close_c     = 1'b1;
            count_n     = FULL_CNT;
            out_valid_n = 1'b1;
            state_n     = HOLD;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (clear) begin
          count_n     = '0;
          out_valid_n = 1'b0;
          state_n     = ACCUM;
        end else if (out_valid && out_ready) begin
          release_c   = 1'b1;
          count_n     = '0;
          out_valid_n = 1'b0;
          state_n     = ACCUM;
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  assign out_count = count;

endmodule

// File: rtl/adder_result_acc.sv
// Sums windows of N_SAMPLES adder results and presents each total on a valid/ready port.
// Optional ADDER_ACC_AVG_EN turns the total into a truncating average.
module adder_result_acc
  import adder_pkg::*;
#(
  parameter int unsigned DATA_W    = ADDER_DATA_W,
  parameter int unsigned N_SAMPLES = 16,
  localparam int unsigned ACC_W = acc_width(DATA_W, N_SAMPLES),
  localparam int unsigned CNT_W = $clog2(N_SAMPLES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  if (N_SAMPLES < 2 || N_SAMPLES > 4096) begin : g_bad_n
    $error("adder_result_acc: N_SAMPLES must be in 2..4096");
  end

  logic             accept_c, close_c, release_c;
  logic [ACC_W-1:0] acc, sum_next, result;

  adder_acc_ctrl #(.N_SAMPLES(N_SAMPLES)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_count (out_count),
    .accept_c  (accept_c),
    .close_c   (close_c),
    .release_c (release_c)
  );

  assign sum_next = acc + ACC_W'(in_data);

`ifdef ADDER_ACC_AVG_EN
  localparam int unsigned LOG_N = $clog2(N_SAMPLES);
  if ((N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_pow2
    $error("adder_result_acc: N_SAMPLES must be a power of two for averaging");
  end
  assign result = sum_next >> LOG_N;
`else
  assign result = sum_next;
`endif

  // Closing sample is folded in directly, so the total lands on the closing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      out_sum <= '0;
    end else if (clear || release_c) begin
      acc <= '0;
    end else if (close_c) begin
      acc     <= '0;
      out_sum <= result;
    end else if (accept_c) begin
      acc <= sum_next;
    end
  end

endmodule

// File: tb/tb_adder_result_acc.sv
// Directed and randomised self-checking bench for adder_result_acc (N_SAMPLES=16).
module tb_adder_result_acc;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned N      = 16;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;

  int errors = 0;
  int checks = 0;

  adder_result_acc #(.DATA_W(DATA_W), .N_SAMPLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_sum(input int s);
`ifdef ADDER_ACC_AVG_EN
    return s >> 4;
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and return 1ns after the edge that accepted it.
  task automatic send(input int d);
    int waited;
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    #1;
    waited = 0;
    while (!in_ready && waited < 100) begin
      step();
      waited++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    step();
  endtask

  initial begin
    int wsum, wcnt, windows, cycles, max_cnt, obs_sum;
    int q[$];
    bit acc_hs;

    // Reset state
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum",   int'(out_sum), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_in_ready",  int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Window 1..16 back to back, out_ready high
    for (int i = 1; i <= 16; i++) begin
      send(i);
      if (i == 1) check("cnt_after_first", int'(out_count), 1);
    end
    in_valid = 1'b0;
    check("w1_out_valid", int'(out_valid), 1);
    check("w1_out_sum",   int'(out_sum), exp_sum(136));
    check("w1_out_count", int'(out_count), 16);
    check("w1_in_ready",  int'(in_ready), 0);
    step();
    check("w1_released_valid", int'(out_valid), 0);
    check("w1_released_ready", int'(in_ready), 1);
    check("w1_released_count", int'(out_count), 0);

    // Full-scale window: no wrap
    for (int i = 0; i < 16; i++) send(4095);
    in_valid = 1'b0;
    check("max_out_sum", int'(out_sum), exp_sum(65520));
    step();

    // Backpressure with in_valid held high
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(100);
    in_data = DATA_W'(7);
    for (int i = 0; i < 20; i++) begin
      check("bp_in_ready",  int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_sum",   int'(out_sum), exp_sum(1600));
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    step();
    check("bp_first_accept", int'(out_count), 1);
    for (int i = 0; i < 15; i++) send(7);
    in_valid = 1'b0;
    check("bp_next_sum", int'(out_sum), exp_sum(112));
    step();

    // clear after two samples discards them
    send(5);
    send(5);
    check("clr_cnt_before", int'(out_count), 2);
    in_data = DATA_W'(9);
    clear   = 1'b1;
    #1;
    check("clr_in_ready", int'(in_ready), 0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_cnt_after", int'(out_count), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(1);
    in_valid = 1'b0;
    check("clr_window_sum", int'(out_sum), exp_sum(16));
    check("clr_window_valid", int'(out_valid), 1);
    // clear while HOLD drops the pending result
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    check("clr_hold_valid", int'(out_valid), 0);
    check("clr_hold_count", int'(out_count), 0);
    check("clr_hold_ready", int'(in_ready), 1);

    // Async reset while HOLD
    for (int i = 0; i < 16; i++) send(50);
    in_valid = 1'b0;
    check("rst_hold_pre_valid", int'(out_valid), 1);
    #3 rst = 1'b1;
    #1;
    check("rst_hold_valid", int'(out_valid), 0);
    check("rst_hold_sum",   int'(out_sum), 0);
    check("rst_hold_count", int'(out_count), 0);
    #2 rst = 1'b0;
    step();

    // Async reset mid-window, then a fresh window
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(50);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rst_mid_count", int'(out_count), 0);
    check("rst_mid_valid", int'(out_valid), 0);
    #2 rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) send(2);
    in_valid = 1'b0;
    check("rst_mid_next_sum", int'(out_sum), exp_sum(32));
    step();

    // Random gaps, 1000 windows against a scoreboard
    wsum = 0; wcnt = 0; windows = 0; cycles = 0; max_cnt = 0;
    while (windows < 1000 && cycles < 80000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = DATA_W'($urandom_range(4095));
      out_ready = ($urandom_range(3) != 0);
      #3;
      if (int'(out_count) > max_cnt) max_cnt = int'(out_count);
      acc_hs = in_valid && in_ready;
      if (out_valid && out_ready) begin
        obs_sum = int'(out_sum);
        if (q.size() == 0) check("rnd_unexpected_out", 1, 0);
        else check("rnd_window_sum", obs_sum, q.pop_front());
        windows++;
      end
      if (acc_hs) begin
        wsum += int'(in_data);
        wcnt++;
        if (wcnt == 16) begin
          q.push_back(exp_sum(wsum));
          wsum = 0;
          wcnt = 0;
        end
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    check("rnd_windows_done", windows, 1000);
    check("rnd_max_count", max_cnt, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
